// File: rtl/mem_arbiter.sv
// Arbitrates the shared pipelined main memory between I-cache fills, D-cache fills and
// D-side write-through stores; steers returning words into the owning cache data array.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           icache_miss,
    input  logic [ADDR_W-1:0]              icache_miss_addr,
    input  logic                           dcache_miss,
    input  logic [ADDR_W-1:0]              dcache_miss_addr,
    input  logic                           dcache_wr,
    input  logic [ADDR_W-1:0]              dcache_wr_addr,
    input  logic [15:0]                    dcache_wr_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [15:0]                    mem_data_out,
    input  logic [15:0]                    mem_data_in,
    input  logic                           mem_data_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           fill_we_i,
    output logic                           fill_we_d,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           wr_done,
    output logic                           busy
);

    localparam int unsigned WordW = $clog2(BLOCK_WORDS);
    // Byte offset bits inside a block: word index plus the 16-bit byte select.
    localparam int unsigned OffW = WordW + 1;
    localparam logic [WordW:0]    NumWords = (WordW + 1)'(BLOCK_WORDS);
    localparam logic [WordW-1:0]  LastWord = WordW'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BaseMask = ~ADDR_W'((1 << OffW) - 1);

    if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LATENCY == 0
        || ADDR_W <= OffW) begin : g_param_check
        $error("mem_arbiter: bad parameters (BLOCK_WORDS power of two, MEM_LATENCY >= 1)");
    end

    typedef enum logic [1:0] {StIdle, StFillI, StFillD, StWrite} state_e;

    state_e              state_q;
    logic [WordW:0]      issue_cnt_q;
    logic [WordW-1:0]    ret_cnt_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [15:0]         wr_data_q;
    logic                issuing;
    logic                filling;

    assign filling = (state_q == StFillI) || (state_q == StFillD);
    assign issuing = filling && (issue_cnt_q < NumWords);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    issue_cnt_q <= '0;
                    ret_cnt_q   <= '0;
                    if (dcache_miss) begin
                        state_q <= StFillD;
                        base_q  <= dcache_miss_addr & BaseMask;
                    end else if (dcache_wr) begin
                        state_q   <= StWrite;
                        wr_addr_q <= dcache_wr_addr;
                        wr_data_q <= dcache_wr_data;
                    end else if (icache_miss) begin
                        state_q <= StFillI;
                        base_q  <= icache_miss_addr & BaseMask;
                    end
                end
                StFillI, StFillD: begin
                    if (issuing) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    // Final return ends the fill regardless of the request level.
                    if (mem_data_valid) begin
                        if (ret_cnt_q == LastWord) begin
                            state_q     <= StIdle;
                            issue_cnt_q <= '0;
                            ret_cnt_q   <= '0;
                        end else begin
                            ret_cnt_q <= ret_cnt_q + 1'b1;
                        end
                    end
                end
                StWrite: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        fill_data    = '0;
        fill_word    = '0;
        fill_we_i    = 1'b0;
        fill_we_d    = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        wr_done      = 1'b0;
        case (state_q)
            StFillI, StFillD: begin
                mem_en    = issuing;
                // Offset never exceeds the block, so the sum cannot carry out of it.
                mem_addr  = issuing ? base_q + ADDR_W'({issue_cnt_q[WordW-1:0], 1'b0}) : '0;
                fill_word = ret_cnt_q;
                if (mem_data_valid) begin
                    fill_data = mem_data_in;
                    fill_we_i = (state_q == StFillI);
                    fill_we_d = (state_q == StFillD);
                    i_done    = (state_q == StFillI) && (ret_cnt_q == LastWord);
                    d_done    = (state_q == StFillD) && (ret_cnt_q == LastWord);
                end
            end
            StWrite: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = wr_addr_q;
                mem_data_out = wr_data_q;
                wr_done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule
